// File: rtl/v68k_bus_pkg.sv
// Shared types and pin-level constants for the V68k bus cycle controller.
package v68k_bus_pkg;

  // Bus cycle phases; StGrant/StHeld are only reachable with BUS_ARB_EN.
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StStrobe,
    StWait,
    StLatch,
    StDone,
    StGrant,
    StHeld
  } bus_state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam logic DS_ON     = 1'b0;
  localparam logic DS_OFF    = 1'b1;
  localparam logic AS_STROBE = 1'b0;
  localparam logic AS_OFF    = 1'b1;
  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;

  // A word access at an odd byte address is an address error.
  function automatic logic odd_word(input logic size, input logic a0);
    return (size == SIZE_WORD) && a0;
  endfunction

endpackage

// File: rtl/dtack_watchdog.sv
// Saturating 8-bit wait-state counter; tc_o flags the configured limit (Limit=0 disables).
module dtack_watchdog #(
  parameter int unsigned Limit = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] LimitW = 8'(Limit);

  logic [7:0] count_q, count_d;

  // Clear dominates; otherwise count up and hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (LimitW != 8'd0) && (count_q == LimitW);

endmodule

// File: rtl/bus_cycle_controller.sv
// 68000-style asynchronous bus cycle sequencer (S0-S7) with DTACK/BERR handshake and
// watchdog. Optional bus arbitration is enabled by defining BUS_ARB_EN.
module bus_cycle_controller
  import v68k_bus_pkg::*;
#(
  parameter int unsigned DTACK_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        req_rw,
  input  logic [23:0] req_addr,
  input  logic        req_size,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_fc,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        berr,
  output logic        aerr,
  output logic        busy,
  output logic [22:0] A,
  output logic [2:0]  FC,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic [15:0] D_IN,
  input  logic        DTACK,
  input  logic        BERR,
  input  logic        BR,
  input  logic        BGACK,
  output logic        BG,
  output logic        BUS_OE
);

  bus_state_e state_q, state_d;

  // Captured request.
  logic        cyc_rw_q, cyc_rw_d;
  logic [23:0] cyc_addr_q, cyc_addr_d;
  logic        cyc_size_q, cyc_size_d;
  logic [15:0] cyc_wdata_q, cyc_wdata_d;
  logic [2:0]  cyc_fc_q, cyc_fc_d;

  // Registered outputs.
  logic        ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;
  logic        aerr_q, aerr_d;
  logic        busy_q, busy_d;
  logic [22:0] a_q, a_d;
  logic [2:0]  fc_q, fc_d;
  logic        as_q, as_d;
  logic        uds_q, uds_d;
  logic        lds_q, lds_d;
  logic        rw_q, rw_d;
  logic [15:0] d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;

  logic wd_tc;
  logic arb_br;
  logic arb_bgack;
  logic odd_d;
  logic uds_en, lds_en;

`ifdef BUS_ARB_EN
  assign arb_br    = ~BR;
  assign arb_bgack = ~BGACK;
`else
  logic unused_arb;
  assign arb_br     = 1'b0;
  assign arb_bgack  = 1'b0;
  assign unused_arb = ^{BR, BGACK};
`endif

  dtack_watchdog #(
    .Limit(DTACK_TIMEOUT)
  ) u_watchdog (
    .clk_i (CLK),
    .rst_ni(RESET),
    .clr_i (state_q != StWait),
    .en_i  (state_q == StWait),
    .tc_o  (wd_tc)
  );

  // Next-state, request capture, and cycle result flags.
  always_comb begin
    state_d     = state_q;
    cyc_rw_d    = cyc_rw_q;
    cyc_addr_d  = cyc_addr_q;
    cyc_size_d  = cyc_size_q;
    cyc_wdata_d = cyc_wdata_q;
    cyc_fc_d    = cyc_fc_q;
    rdata_d     = rdata_q;
    berr_d      = 1'b0;
    aerr_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_br) begin
          state_d = StGrant;
        end else if (req) begin
          cyc_rw_d    = req_rw;
          cyc_addr_d  = req_addr;
          cyc_size_d  = req_size;
          cyc_wdata_d = req_wdata;
          cyc_fc_d    = req_fc;
          state_d     = StAddr;
        end
      end
      StAddr: begin
        if (odd_word(cyc_size_q, cyc_addr_q[0])) begin
          aerr_d  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StStrobe;
        end
      end
      StStrobe: state_d = StWait;
      StWait: begin
        // BERR outranks DTACK, which outranks the watchdog.
        if (!BERR) begin
          berr_d  = 1'b1;
          state_d = StDone;
        end else if (!DTACK) begin
          state_d = StLatch;
        end else if (wd_tc) begin
          berr_d  = 1'b1;
          state_d = StDone;
        end
      end
      StLatch: begin
        if (cyc_rw_q == RW_READ) begin
          if (cyc_size_q == SIZE_WORD) begin
            rdata_d = D_IN;
          end else if (cyc_addr_q[0]) begin
            rdata_d = {8'h00, D_IN[7:0]};
          end else begin
            rdata_d = {8'h00, D_IN[15:8]};
          end
        end
        state_d = StDone;
      end
      StDone:  state_d = arb_br ? StGrant : StIdle;
      StGrant: if (arb_bgack) state_d = StHeld;
      StHeld:  if (!arb_bgack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin values for the phase being entered, so every output comes straight from a flop.
  always_comb begin
    odd_d   = odd_word(cyc_size_d, cyc_addr_d[0]);
    uds_en  = (cyc_size_d == SIZE_WORD) || !cyc_addr_d[0];
    lds_en  = (cyc_size_d == SIZE_WORD) || cyc_addr_d[0];
    a_d     = a_q;
    fc_d    = fc_q;
    as_d    = AS_OFF;
    uds_d   = DS_OFF;
    lds_d   = DS_OFF;
    rw_d    = RW_READ;
    d_out_d = d_out_q;
    d_oe_d  = 1'b0;
    ack_d   = (state_d == StDone);
    busy_d  = (state_d != StIdle);
    unique case (state_d)
      StAddr: begin
        if (!odd_d) begin
          a_d  = cyc_addr_d[23:1];
          fc_d = cyc_fc_d;
          rw_d = cyc_rw_d;
        end
      end
      StStrobe: begin
        as_d = AS_STROBE;
        rw_d = cyc_rw_d;
        if (cyc_rw_d == RW_READ) begin
          uds_d = uds_en ? DS_ON : DS_OFF;
          lds_d = lds_en ? DS_ON : DS_OFF;
        end else begin
          d_oe_d  = 1'b1;
          d_out_d = (cyc_size_d == SIZE_WORD) ? cyc_wdata_d
                                              : {cyc_wdata_d[7:0], cyc_wdata_d[7:0]};
        end
      end
      StWait, StLatch: begin
        as_d   = AS_STROBE;
        rw_d   = cyc_rw_d;
        uds_d  = uds_en ? DS_ON : DS_OFF;
        lds_d  = lds_en ? DS_ON : DS_OFF;
        d_oe_d = (cyc_rw_d == RW_WRITE);
      end
      StDone: begin
        // An aborted odd access never drove the bus, so it leaves RW/D alone.
        rw_d   = odd_d ? RW_READ : cyc_rw_d;
        d_oe_d = !odd_d && (cyc_rw_d == RW_WRITE);
      end
      default: ;
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      cyc_rw_q    <= RW_READ;
      cyc_addr_q  <= 24'h0;
      cyc_size_q  <= SIZE_BYTE;
      cyc_wdata_q <= 16'h0;
      cyc_fc_q    <= 3'h0;
      ack_q       <= 1'b0;
      rdata_q     <= 16'h0;
      berr_q      <= 1'b0;
      aerr_q      <= 1'b0;
      busy_q      <= 1'b0;
      a_q         <= 23'h0;
      fc_q        <= 3'h0;
      as_q        <= AS_OFF;
      uds_q       <= DS_OFF;
      lds_q       <= DS_OFF;
      rw_q        <= RW_READ;
      d_out_q     <= 16'h0;
      d_oe_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_rw_q    <= cyc_rw_d;
      cyc_addr_q  <= cyc_addr_d;
      cyc_size_q  <= cyc_size_d;
      cyc_wdata_q <= cyc_wdata_d;
      cyc_fc_q    <= cyc_fc_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      berr_q      <= berr_d;
      aerr_q      <= aerr_d;
      busy_q      <= busy_d;
      a_q         <= a_d;
      fc_q        <= fc_d;
      as_q        <= as_d;
      uds_q       <= uds_d;
      lds_q       <= lds_d;
      rw_q        <= rw_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
    end
  end

`ifdef BUS_ARB_EN
  logic bg_q, bg_d;
  logic bus_oe_q, bus_oe_d;

  // Grant outputs follow the arbitration phase being entered.
  always_comb begin
    bg_d     = (state_d != StGrant);
    bus_oe_d = !((state_d == StGrant) || (state_d == StHeld));
  end

  // Arbitration output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bg_q     <= 1'b1;
      bus_oe_q <= 1'b1;
    end else begin
      bg_q     <= bg_d;
      bus_oe_q <= bus_oe_d;
    end
  end

  assign BG     = bg_q;
  assign BUS_OE = bus_oe_q;
`else
  assign BG     = 1'b1;
  assign BUS_OE = 1'b1;
`endif

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign berr  = berr_q;
  assign aerr  = aerr_q;
  assign busy  = busy_q;
  assign A     = a_q;
  assign FC    = fc_q;
  assign AS    = as_q;
  assign UDS   = uds_q;
  assign LDS   = lds_q;
  assign RW    = rw_q;
  assign D_OUT = d_out_q;
  assign D_OE  = d_oe_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Bench for bus_cycle_controller: directed cases plus random cycles against a latency/data model.
module tb_bus_cycle_controller;

  localparam int unsigned Timeout = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req;
  logic        req_rw;
  logic [23:0] req_addr;
  logic        req_size;
  logic [15:0] req_wdata;
  logic [2:0]  req_fc;
  logic        ack;
  logic [15:0] rdata;
  logic        berr;
  logic        aerr;
  logic        busy;
  logic [22:0] A;
  logic [2:0]  FC;
  logic        AS, UDS, LDS, RW;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic [15:0] D_IN;
  logic        DTACK, BERR, BR, BGACK;
  logic        BG, BUS_OE;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] rdata_m;

  always #5 CLK = ~CLK;

  bus_cycle_controller #(
    .DTACK_TIMEOUT(Timeout)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .req      (req),
    .req_rw   (req_rw),
    .req_addr (req_addr),
    .req_size (req_size),
    .req_wdata(req_wdata),
    .req_fc   (req_fc),
    .ack      (ack),
    .rdata    (rdata),
    .berr     (berr),
    .aerr     (aerr),
    .busy     (busy),
    .A        (A),
    .FC       (FC),
    .AS       (AS),
    .UDS      (UDS),
    .LDS      (LDS),
    .RW       (RW),
    .D_OUT    (D_OUT),
    .D_OE     (D_OE),
    .D_IN     (D_IN),
    .DTACK    (DTACK),
    .BERR     (BERR),
    .BR       (BR),
    .BGACK    (BGACK),
    .BG       (BG),
    .BUS_OE   (BUS_OE)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ctl"}, {AS, UDS, LDS, RW, BG, BUS_OE, D_OE, ack, berr, aerr, busy},
             32'b111111_00000);
    check_eq({tag, "_a"}, {9'h0, A}, 32'h0);
    check_eq({tag, "_fc"}, {29'h0, FC}, 32'h0);
    check_eq({tag, "_rdata"}, {16'h0, rdata}, 32'h0);
    check_eq({tag, "_dout"}, {16'h0, D_OUT}, 32'h0);
  endtask

  // mode: 0 DTACK after w waits, 1 BERR after w waits, 2 both together, 3 no response.
  task automatic run_cycle(input logic rw, input logic [23:0] addr, input logic size,
                           input logic [15:0] wdata, input logic [2:0] fc,
                           input logic [15:0] din, input int w, input int mode);
    logic        odd, uds_e, lds_e, exp_berr;
    logic [15:0] exp_rdata, exp_dout;
    int          exp_lat;
    bit          got_ack;
    odd       = size && addr[0];
    uds_e     = size || !addr[0];
    lds_e     = size || addr[0];
    exp_dout  = size ? wdata : {wdata[7:0], wdata[7:0]};
    exp_berr  = 1'b0;
    exp_rdata = rdata_m;
    if (odd) begin
      exp_lat = 2;
    end else if (mode == 3 || w > int'(Timeout)) begin
      exp_lat  = int'(Timeout) + 4;
      exp_berr = 1'b1;
    end else if (mode == 0) begin
      exp_lat = 5 + w;
      if (rw) exp_rdata = size ? din : (addr[0] ? {8'h00, din[7:0]} : {8'h00, din[15:8]});
    end else begin
      exp_lat  = 4 + w;
      exp_berr = 1'b1;
    end

    @(negedge CLK);
    req = 1'b1; req_rw = rw; req_addr = addr; req_size = size;
    req_wdata = wdata; req_fc = fc; D_IN = din; DTACK = 1'b1; BERR = 1'b1;
    got_ack = 1'b0;
    for (int e = 1; e <= 20 && !got_ack; e++) begin
      @(negedge CLK);
      if (odd) check_eq("aerr_no_as", {31'h0, AS}, 32'h1);
      if (e == 1 && !odd) begin
        check_eq("addr_a", {9'h0, A}, {9'h0, addr[23:1]});
        check_eq("addr_rw", {31'h0, RW}, {31'h0, rw});
        check_eq("addr_as", {31'h0, AS}, 32'h1);
      end
      if (e == 2 && !odd) begin
        check_eq("strobe_as", {31'h0, AS}, 32'h0);
        check_eq("strobe_fc", {29'h0, FC}, {29'h0, fc});
        if (rw) begin
          check_eq("strobe_rd_ds", {30'h0, UDS, LDS}, {30'h0, !uds_e, !lds_e});
        end else begin
          check_eq("strobe_wr_ds", {30'h0, UDS, LDS}, 32'h3);
          check_eq("strobe_wr_oe", {31'h0, D_OE}, 32'h1);
          check_eq("strobe_wr_dout", {16'h0, D_OUT}, {16'h0, exp_dout});
        end
      end
      if (e == 3 && !odd) begin
        check_eq("wait_ds", {30'h0, UDS, LDS}, {30'h0, !uds_e, !lds_e});
        check_eq("wait_rw", {31'h0, RW}, {31'h0, rw});
      end
      check_eq("busy_in_cycle", {31'h0, busy}, 32'h1);
      if (ack) begin
        got_ack = 1'b1;
        check_eq("ack_edge", e, exp_lat);
        check_eq("done_flags", {30'h0, berr, aerr}, {30'h0, exp_berr, odd});
        check_eq("done_rdata", {16'h0, rdata}, {16'h0, exp_rdata});
        check_eq("done_strobes", {29'h0, AS, UDS, LDS}, 32'h7);
        check_eq("done_rw_oe", {30'h0, RW, D_OE}, {30'h0, odd | rw, !odd && !rw});
        check_eq("done_arb", {30'h0, BG, BUS_OE}, 32'h3);
        req = 1'b0;
        rdata_m = exp_rdata;
      end
      DTACK = !((mode == 0 || mode == 2) && e >= 3 + w);
      BERR  = !((mode == 1 || mode == 2) && e >= 3 + w);
    end
    if (!got_ack) begin
      check_eq("ack_timeout", 32'h0, 32'h1);
      req = 1'b0;
    end
    DTACK = 1'b1; BERR = 1'b1;
    @(negedge CLK);
    check_eq("idle_after", {29'h0, ack, busy, D_OE}, 32'h0);
  endtask

  initial begin
    RESET = 1'b0; req = 1'b0; req_rw = 1'b1; req_addr = 24'h0; req_size = 1'b0;
    req_wdata = 16'h0; req_fc = 3'h0; D_IN = 16'h0; DTACK = 1'b1; BERR = 1'b1;
    BR = 1'b1; BGACK = 1'b1;
    rdata_m = 16'h0;
    #12;
    check_reset_vals("reset");
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    run_cycle(1'b1, 24'h001000, 1'b1, 16'h0000, 3'h5, 16'hBEEF, 0, 0);
    run_cycle(1'b0, 24'h000201, 1'b0, 16'h005A, 3'h1, 16'h1234, 3, 0);
    run_cycle(1'b1, 24'h000003, 1'b1, 16'h0000, 3'h2, 16'h4321, 0, 0);
    run_cycle(1'b1, 24'h000400, 1'b1, 16'h0000, 3'h6, 16'h7777, 0, 3);
    run_cycle(1'b1, 24'h000402, 1'b1, 16'h0000, 3'h6, 16'h9999, 1, 2);
    run_cycle(1'b1, 24'h000402, 1'b0, 16'h0000, 3'h6, 16'hA55A, 0, 0);

    // Reset pulsed while the cycle sits in WAIT.
    @(negedge CLK);
    req = 1'b1; req_rw = 1'b0; req_addr = 24'h000800; req_size = 1'b1; req_wdata = 16'hCAFE;
    repeat (3) @(negedge CLK);
    check_eq("pre_reset_as", {31'h0, AS}, 32'h0);
    RESET = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    rdata_m = 16'h0;
    req = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

`ifdef BUS_ARB_EN
    @(negedge CLK);
    req = 1'b1; req_rw = 1'b1; req_addr = 24'h000100; req_size = 1'b1; BR = 1'b0;
    @(negedge CLK);
    check_eq("grant", {29'h0, BG, BUS_OE, busy}, 32'h1);
    check_eq("grant_as", {31'h0, AS}, 32'h1);
    BGACK = 1'b0;
    @(negedge CLK);
    check_eq("held", {29'h0, BG, BUS_OE, busy}, 32'h5);
    BGACK = 1'b1; BR = 1'b1; req = 1'b0;
    @(negedge CLK);
    check_eq("released", {29'h0, BG, BUS_OE, busy}, 32'h6);
    run_cycle(1'b1, 24'h000100, 1'b1, 16'h0000, 3'h5, 16'h0F0F, 1, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic        r_rw, r_size;
      logic [23:0] r_addr;
      logic [15:0] r_wdata, r_din;
      logic [2:0]  r_fc;
      r_rw    = 1'($urandom_range(0, 1));
      r_size  = 1'($urandom_range(0, 1));
      r_addr  = 24'($urandom);
      r_wdata = 16'($urandom);
      r_din   = 16'($urandom);
      r_fc    = 3'($urandom);
`ifndef BUS_ARB_EN
      BR    = 1'($urandom_range(0, 1));
      BGACK = 1'($urandom_range(0, 1));
`endif
      run_cycle(r_rw, r_addr, r_size, r_wdata, r_fc, r_din, int'($urandom_range(0, 6)),
                int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bus_cycle_controller.md
# bus_cycle_controller

Sequences 68000-style asynchronous bus cycles on behalf of the V68k core datapath. It accepts one read or write request at a time from the core's execution state machine and drives A/FC/AS/UDS/LDS/RW/D with the S0–S7 phase ordering. It completes each cycle on the DTACK or BERR handshake, or on a watchdog timeout. It sits between the core sequencer and the top-level pins; the top level owns the D tristate.

## Interface
Parameters:
- DTACK_TIMEOUT, 64: wait cycles in WAIT before forced bus error; 0 disables the watchdog (max 255).

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-low reset
- req  in  1  core requests a bus cycle; held until ack
- req_rw  in  1  1 read, 0 write
- req_addr  in  24  byte address
- req_size  in  1  0 byte, 1 word
- req_wdata  in  16  write data (byte writes use [7:0])
- req_fc  in  3  function code for this cycle
- ack  out  1  one-cycle completion pulse
- rdata  out  16  read data, valid with ack
- berr  out  1  bus error or timeout, valid with ack
- aerr  out  1  address error (odd word access), valid with ack
- busy  out  1  high whenever state ≠ IDLE
- A  out  23  address bits [23:1]
- FC  out  3  function code
- AS, UDS, LDS  out  1 each  active-low strobes
- RW  out  1  1 read, 0 write
- D_OUT  out  16  write data to pins
- D_OE  out  1  top level drives D when high
- D_IN  in  16  data pins
- DTACK, BERR  in  1 each  active-low
- BR, BGACK  in  1 each  active-low arbitration inputs
- BG  out  1  active-low bus grant
- BUS_OE  out  1  high while this block owns A/AS/UDS/LDS/RW

## Operation
- IDLE: all strobes negated, RW=1, D_OE=0. A req sampled high is captured into internal registers; the next state is then ADDR.
- Odd word access (req_size=1, req_addr[0]=1): no bus activity; the next state is DONE with aerr=1.
- ADDR (S0–S1): drive A=addr[23:1], FC and RW; AS and DS stay negated.
- STROBE (S2–S3): assert AS. For a read, also assert the DS lanes. For a write, D_OE=1 and D_OUT=data.
- WAIT (S4–S5): for a write, assert the DS lanes. Sample the handshake inputs every edge:
  - BERR low: go to DONE with berr=1.
  - Otherwise DTACK low: go to LATCH.
  - Otherwise the counter reaching DTACK_TIMEOUT: go to DONE with berr=1.
- LATCH (S6): rdata ← D_IN. For a byte read, the selected lane goes to rdata[7:0] and [15:8]=0.
- DONE (S7): negate AS/UDS/LDS. D_OE stays high this cycle for writes. ack=1. The next state is IDLE.
- Lanes:
  - Word access: UDS and LDS.
  - Byte access, addr[0]=0: UDS, D[15:8].
  - Byte access, addr[0]=1: LDS, D[7:0].
  - Byte writes replicate the byte on both halves of D_OUT.
- req while busy is ignored. A new acceptance happens only from IDLE, so at least one IDLE cycle separates cycles.
- BERR and DTACK low together: BERR wins.

## Timing
- All outputs are registered.
- Reset values:
  - AS=UDS=LDS=1, RW=1, BG=1, BUS_OE=1.
  - D_OE=0, ack=0, berr=0, aerr=0, busy=0.
  - A=0, FC=0, rdata=0, D_OUT=0.
- Reset asserted mid-cycle forces these values immediately and returns the state to IDLE.
- Zero-wait cycle (DTACK already low): request accepted at edge 0; ack is sampled high at edge 5. Each cycle with DTACK high in WAIT adds one edge.
- Address error: ack and aerr are sampled high at edge 2.
- Watchdog: the count resets on entry to WAIT. With DTACK_TIMEOUT=N, berr is sampled with ack at edge N+4.

## Configuration
- BUS_ARB_EN defined:
  - A BR low seen in IDLE, or in DONE, wins over a pending req.
  - The state moves to GRANT: BG=0, BUS_OE=0.
  - BGACK low then moves it to HELD with BG=1.
  - BGACK high moves it back to IDLE with BUS_OE=1.
  - busy is high in GRANT and HELD.
- BUS_ARB_EN undefined: BG is tied 1, BUS_OE is tied 1, and BR/BGACK are ignored.

## Structure
- Package v68k_bus_pkg holds:
  - The state enum.
  - SIZE_BYTE/SIZE_WORD.
  - DS_ON/DS_OFF, AS_STROBE/AS_OFF, RW_READ/RW_WRITE.
- Sub-module dtack_watchdog: an 8-bit counter with clear, enable and a terminal-count output, instantiated once.

## Test plan
- Word read at 0x001000, DTACK low throughout, D_IN=0xBEEF → A=0x000800, UDS=LDS=0 in STROBE, ack at edge 5, rdata=0xBEEF, berr=0.
- Byte write 0x5A at 0x000201, DTACK delayed 3 cycles → only LDS asserted, D_OUT=0x5A5A, RW=0 from ADDR through DONE, ack at edge 8.
- Word read at 0x000003 → no AS strobe, ack+aerr at edge 2.
- DTACK never asserted, DTACK_TIMEOUT=4 → ack+berr at edge 8, strobes negated in DONE.
- DTACK and BERR low in the same WAIT cycle → berr=1, rdata unchanged; RESET pulsed low during WAIT → all outputs at reset values within the same cycle.
- BUS_ARB_EN defined, BR low with req pending → BG=0, BUS_OE=0; BGACK low→high → IDLE, pending req then completes normally.
